// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain scheduler: CSR map, register bit
// positions and the scheduler state encoding.
package fifo_drain_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_THRESH  = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_FLUSH       = 2;
    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_IRQ       = 1;
    localparam int STATUS_USEDW_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_drain_timer.sv
// Saturating partial-fill timer. Counts while run is high, clears when run
// drops or clr pulses, and flags expiry against a programmable limit.
module fifo_drain_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 clr,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr || !run) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit disables the trigger entirely.
    assign expired = (timeout != '0) && (count_q >= timeout);

endmodule

// File: rtl/fifo_drain_sched.sv
// Drain scheduler: watches the FIFO fill level and raises burst requests on
// threshold, timeout or flush; Avalon-MM CSR slave plus completion IRQ.
module fifo_drain_sched
    import fifo_drain_pkg::*;
#(
    parameter int USEDW_W   = 16,
    parameter int BURST_MAX = 64,
    parameter int TIMEOUT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [USEDW_W-1:0] usedw,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               burst_req,
    output logic [USEDW_W-1:0] burst_len,
    input  logic               burst_ack,
    input  logic               burst_done,
    output logic               irq,
    output logic [1:0]         state_dbg
);

    localparam logic [USEDW_W-1:0] BURST_MAX_W = USEDW_W'(BURST_MAX);

    state_e               state_q, state_d;
    logic [USEDW_W-1:0]   usedw_q, thresh_q, thresh_d, burst_len_q, burst_len_d;
    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic                 enable_q, enable_d, irq_en_q, irq_en_d, flush_q, flush_d;
    logic                 irq_pending_q, irq_pending_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 wr_ctrl, wr_thresh, wr_timeout, wr_status;
    logic                 timer_run, timer_expired, trig, issue, complete;
    logic [USEDW_W-1:0]   thresh_eff;
    logic                 unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    assign wr_thresh  = avs_write && (avs_address == ADDR_THRESH);
    assign wr_timeout = avs_write && (avs_address == ADDR_TIMEOUT);
    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);

    assign thresh_eff = (thresh_q == '0) ? USEDW_W'(1) : thresh_q;
    assign timer_run  = (state_q == ST_IDLE) && enable_q && (usedw_q != '0);
    assign trig       = (usedw_q >= thresh_eff) || timer_expired || flush_q;

    fifo_drain_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (timer_run),
        .clr     (issue),
        .timeout (timeout_q),
        .expired (timer_expired)
    );

    // burst_req/burst_ack is valid/ready: once burst_req rises, burst_len is
    // held and the request stays up until burst_ack is sampled high; it is
    // never withdrawn, even if enable is cleared meanwhile.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q && (usedw_q != '0) && trig) begin
                    state_d = ST_REQ;
                    issue   = 1'b1;
                end
            end
            ST_REQ: begin
                if (burst_ack && burst_done) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end else if (burst_ack) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (burst_done) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        burst_req = (state_q == ST_REQ);
        state_dbg = state_q;
    end

    always_comb begin
        burst_len_d = burst_len_q;
        if (issue) begin
            burst_len_d = (usedw_q > BURST_MAX_W) ? BURST_MAX_W : usedw_q;
        end

        enable_d = wr_ctrl ? avs_writedata[CTRL_ENABLE] : enable_q;
        irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;
        flush_d  = wr_ctrl ? avs_writedata[CTRL_FLUSH]  : flush_q;
        if (issue || (usedw_q == '0)) begin
            flush_d = 1'b0;
        end

        thresh_d  = wr_thresh  ? avs_writedata[USEDW_W-1:0]   : thresh_q;
        timeout_d = wr_timeout ? avs_writedata[TIMEOUT_W-1:0] : timeout_q;

        // A completion in the same cycle as a W1C keeps the interrupt pending.
        irq_pending_d = irq_pending_q;
        if (wr_status && avs_writedata[STATUS_IRQ]) begin
            irq_pending_d = 1'b0;
        end
        if (complete) begin
            irq_pending_d = 1'b1;
        end

        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = '0;
            case (avs_address)
                ADDR_CTRL: begin
                    readdata_d[CTRL_ENABLE] = enable_q;
                    readdata_d[CTRL_IRQ_EN] = irq_en_q;
                    readdata_d[CTRL_FLUSH]  = flush_q;
                end
                ADDR_THRESH:  readdata_d[USEDW_W-1:0]   = thresh_q;
                ADDR_TIMEOUT: readdata_d[TIMEOUT_W-1:0] = timeout_q;
                default: begin
                    readdata_d[STATUS_BUSY] = (state_q != ST_IDLE);
                    readdata_d[STATUS_IRQ]  = irq_pending_q;
                    readdata_d[STATUS_USEDW_LSB +: USEDW_W] = usedw_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            usedw_q       <= '0;
            burst_len_q   <= '0;
            enable_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            flush_q       <= 1'b0;
            thresh_q      <= '0;
            timeout_q     <= '0;
            irq_pending_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            usedw_q       <= usedw;
            burst_len_q   <= burst_len_d;
            enable_q      <= enable_d;
            irq_en_q      <= irq_en_d;
            flush_q       <= flush_d;
            thresh_q      <= thresh_d;
            timeout_q     <= timeout_d;
            irq_pending_q <= irq_pending_d;
            readdata_q    <= readdata_d;
        end
    end

    assign burst_len    = burst_len_q;
    assign avs_readdata = readdata_q;
    assign irq          = irq_pending_q & irq_en_q;

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Self-checking bench for fifo_drain_sched: CSR vector table followed by
// hand-written burst sequences for the trigger and completion corner cases.
module tb_fifo_drain_sched;
    import fifo_drain_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] usedw;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        burst_req, burst_ack, burst_done, irq;
    logic [15:0] burst_len;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] burst_q[$];

    fifo_drain_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .usedw         (usedw),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .burst_req     (burst_req),
        .burst_len     (burst_len),
        .burst_ack     (burst_ack),
        .burst_done    (burst_done),
        .irq           (irq),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_write = 1'b1; avs_address = addr; avs_writedata = data;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic csr_read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        avs_read = 1'b1; avs_address = addr;
        @(negedge clk);
        avs_read = 1'b0;
        check(name, avs_readdata, exp_q.pop_front());
    endtask

    task automatic expect_burst(input string name, input int max_cycles);
        int c = 0;
        while (!burst_req && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        if (!burst_req) begin
            checks++;
            errors++;
            $display("FAIL %s: burst_req not seen within %0d cycles", name, max_cycles);
            if (burst_q.size() != 0) void'(burst_q.pop_front());
        end else begin
            check(name, {16'h0, burst_len}, burst_q.pop_front());
        end
    endtask

    task automatic finish_burst();
        burst_ack = 1'b1; usedw = 16'd0;
        @(negedge clk);
        burst_ack = 1'b0;
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
    endtask

    task automatic count_reqs(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (burst_req) cnt++;
        end
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    csr_vec_t vecs[7];

    initial begin
        int cnt;
        int lat;
        vecs[0] = '{ADDR_CTRL,    32'hFFFF_FFFA, 32'h0000_0002};
        vecs[1] = '{ADDR_THRESH,  32'hFFFF_1234, 32'h0000_1234};
        vecs[2] = '{ADDR_TIMEOUT, 32'hABCD_5678, 32'h0000_5678};
        vecs[3] = '{ADDR_STATUS,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{ADDR_THRESH,  32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{ADDR_TIMEOUT, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{ADDR_CTRL,    32'h0000_0000, 32'h0000_0000};

        reset_n = 1'b0; usedw = '0; avs_address = '0; avs_read = 1'b0;
        avs_write = 1'b0; avs_writedata = '0; burst_ack = 1'b0; burst_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_burst_req", {31'h0, burst_req}, 0);
        check("rst_burst_len", {16'h0, burst_len}, 0);
        check("rst_irq", {31'h0, irq}, 0);
        check("rst_readdata", avs_readdata, 0);
        check("rst_state", {30'h0, state_dbg}, {30'h0, ST_IDLE});
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            csr_write(vecs[i].addr, vecs[i].wdata);
            csr_read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Case 1: threshold crossing latency, completion, irq gating
        csr_write(ADDR_THRESH, 32);
        csr_write(ADDR_CTRL, 32'h1);
        for (int v = 0; v <= 32; v++) begin
            @(negedge clk);
            usedw = 16'(v);
        end
        burst_q.push_back(32);
        @(negedge clk);
        check("c1_req_cycle1", {31'h0, burst_req}, 0);
        @(negedge clk);
        check("c1_req_cycle2", {31'h0, burst_req}, 1);
        check("c1_len", {16'h0, burst_len}, burst_q.pop_front());
        burst_ack = 1'b1; usedw = 16'd0;
        @(negedge clk);
        burst_ack = 1'b0;
        check("c1_req_dropped", {31'h0, burst_req}, 0);
        csr_read_check("c1_status_busy", ADDR_STATUS, 32'h1);
        @(negedge clk);
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        check("c1_irq_masked", {31'h0, irq}, 0);
        csr_read_check("c1_status_pending", ADDR_STATUS, 32'h2);
        csr_write(ADDR_CTRL, 32'h3);
        check("c1_irq_enabled", {31'h0, irq}, 1);
        csr_write(ADDR_STATUS, 32'h2);
        check("c1_irq_cleared", {31'h0, irq}, 0);

        // Case 2: length capped to BURST_MAX, then sub-threshold fill stays idle
        csr_write(ADDR_THRESH, 40);
        @(negedge clk);
        usedw = 16'd100;
        burst_q.push_back(64);
        expect_burst("c2_len_capped", 10);
        finish_burst();
        usedw = 16'd36;
        count_reqs(1000, cnt);
        check("c2_no_req", cnt, 0);
        csr_read_check("c2_status", ADDR_STATUS, {16'd36, 16'h2});

        // Case 3: timeout trigger with partial fill, then ack+done together
        @(negedge clk);
        usedw = 16'd0;
        csr_write(ADDR_STATUS, 32'h2);
        csr_write(ADDR_TIMEOUT, 10);
        @(negedge clk);
        usedw = 16'd5;
        burst_q.push_back(5);
        lat = 0;
        while (!burst_req && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("c3_timeout_latency", lat, 12);
        check("c3_len", {16'h0, burst_len}, burst_q.pop_front());
        burst_ack = 1'b1; burst_done = 1'b1; usedw = 16'd0;
        @(negedge clk);
        burst_ack = 1'b0; burst_done = 1'b0;
        check("c3_ackdone_idle", {30'h0, state_dbg}, {30'h0, ST_IDLE});
        csr_read_check("c3_status", ADDR_STATUS, 32'h2);
        csr_write(ADDR_TIMEOUT, 0);
        csr_write(ADDR_STATUS, 32'h2);
        @(negedge clk);
        usedw = 16'd5;
        count_reqs(300, cnt);
        check("c3_timeout_off", cnt, 0);
        usedw = 16'd0;

        // Case 4: W1C colliding with completion
        csr_write(ADDR_THRESH, 8);
        @(negedge clk);
        usedw = 16'd8;
        burst_q.push_back(8);
        expect_burst("c4_len", 10);
        burst_ack = 1'b1; usedw = 16'd0;
        @(negedge clk);
        burst_ack = 1'b0;
        burst_done = 1'b1;
        avs_write = 1'b1; avs_address = ADDR_STATUS; avs_writedata = 32'h2;
        @(negedge clk);
        burst_done = 1'b0; avs_write = 1'b0;
        check("c4_irq_set_wins", {31'h0, irq}, 1);
        csr_read_check("c4_status_set", ADDR_STATUS, 32'h2);
        csr_write(ADDR_STATUS, 32'h2);
        check("c4_irq_w1c", {31'h0, irq}, 0);
        csr_read_check("c4_status_clr", ADDR_STATUS, 32'h0);

        // Case 5: flush with partial fill, and flush on an empty FIFO
        csr_write(ADDR_THRESH, 40);
        @(negedge clk);
        usedw = 16'd3;
        repeat (3) @(negedge clk);
        burst_q.push_back(3);
        csr_write(ADDR_CTRL, 32'h7);
        expect_burst("c5_flush_len", 10);
        csr_read_check("c5_flush_selfclr", ADDR_CTRL, 32'h3);
        finish_burst();
        csr_write(ADDR_STATUS, 32'h2);
        csr_write(ADDR_CTRL, 32'h7);
        count_reqs(50, cnt);
        check("c5_empty_flush_noreq", cnt, 0);
        csr_read_check("c5_empty_flush_clr", ADDR_CTRL, 32'h3);

        // Case 6: reset mid-transfer
        csr_write(ADDR_THRESH, 8);
        @(negedge clk);
        usedw = 16'd8;
        burst_q.push_back(8);
        expect_burst("c6_len", 10);
        burst_ack = 1'b1; usedw = 16'd0;
        @(negedge clk);
        burst_ack = 1'b0;
        check("c6_in_xfer", {30'h0, state_dbg}, {30'h0, ST_XFER});
        reset_n = 1'b0;
        #1;
        check("c6_rst_req", {31'h0, burst_req}, 0);
        check("c6_rst_state", {30'h0, state_dbg}, {30'h0, ST_IDLE});
        check("c6_rst_len", {16'h0, burst_len}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        csr_read_check("c6_ctrl", ADDR_CTRL, 0);
        csr_read_check("c6_thresh", ADDR_THRESH, 0);
        csr_read_check("c6_timeout", ADDR_TIMEOUT, 0);
        @(negedge clk);
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        repeat (5) @(negedge clk);
        check("c6_no_irq", {31'h0, irq}, 0);
        csr_read_check("c6_status", ADDR_STATUS, 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
